opb_register_bank_ppc2simulink: RTL and testbench

Parametrised successor to the single-word PPC-to-Simulink OPB register. Exposes `N_REGS` 32-bit software-writable registers on the OPB as one bank, with shadow/live double-buffering so that related values update together; FIR coefficient pairs are the motivating case. It also supports byte-enable writes, readback, an auto-commit mode and a commit counter. User logic runs on `OPB_Clk`; there is one clock domain and no CDC.

---
 rtl/opb_regbank_pkg.sv | 25 ++
 rtl/opb_regbank_slice.sv | 39 +++
 rtl/opb_register_bank_ppc2simulink.sv | 163 ++++++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_regbank_pkg.sv
// Shared types, CTRL register layout and byte-lane merge for the OPB register bank.
package opb_regbank_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_CNT_LSB = 16;
    localparam int CNT_W        = 16;

    // be[0] enables bits [7:0]; callers present OPB_BE reversed so lane 0 is the LSB byte.
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/opb_regbank_slice.sv
// One shadow/live register pair. Shadow takes bus writes; live follows on commit,
// or alongside the shadow when writes are direct (auto-commit).
module opb_regbank_slice
    import opb_regbank_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    input  logic        commit,
    input  logic        direct,
    output logic [31:0] shadow,
    output logic [31:0] live
);

    logic [31:0] r_shadow;
    logic [31:0] r_live;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_live   <= '0;
        end else begin
            if (wr_en) begin
                r_shadow <= be_merge(r_shadow, wdata, be);
            end
            if (commit) begin
                r_live <= r_shadow;
            end else if (wr_en && direct) begin
                r_live <= be_merge(r_live, wdata, be);
            end
        end
    end

    assign shadow = r_shadow;
    assign live   = r_live;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing N_REGS double-buffered 32-bit registers plus a CTRL word
// (commit strobe, auto-commit mode, commit counter) to user logic.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter int                      C_OPB_AWIDTH = 32,
    parameter int                      C_OPB_DWIDTH = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h01000A00,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h01000AFF,
    parameter int                      N_REGS       = 4,
    parameter int                      READ_LIVE    = 0
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:31]             OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:31]             Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic [32*N_REGS-1:0]    user_data_out,
    output logic                    user_update
);

    localparam int AW = C_OPB_AWIDTH;

    state_t             r_state;
    logic               r_rnw_p1;
    logic [AW-1:0]      r_widx_p1;
    logic [31:0]        r_rdata_p1;
    logic               r_auto;
    logic [CNT_W-1:0]   r_count;
    logic               r_update;

    logic [AW-1:0]      w_addr;
    logic [AW-1:0]      w_offset;
    logic [AW-1:0]      w_widx_p0;
    logic               w_hit_p0;
    logic [31:0]        w_rd_p0;
    logic [31:0]        w_ctrl;
    logic [31:0]        w_wdata;
    logic [3:0]         w_be;
    logic               w_wr_p1;
    logic               w_data_wr_p1;
    logic               w_ctrl_wr_p1;
    logic               w_commit_p1;
    logic               w_bump_p1;
    logic [31:0]        w_shadow [N_REGS];
    logic [31:0]        w_live   [N_REGS];
    logic               w_unused_seq;

    // Big-endian bus vectors land in LSB-0 vectors bit-reversed: DBus[31] -> bit 0, BE[3] -> lane 0.
    assign w_addr       = OPB_ABus;
    assign w_wdata      = OPB_DBus;
    assign w_be         = OPB_BE;
    assign w_unused_seq = OPB_seqAddr;

    // ---- p0: request decode and read mux ----
    assign w_offset  = w_addr - C_BASEADDR;
    assign w_widx_p0 = w_offset >> 2;
    assign w_hit_p0  = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);

    always_comb begin
        w_ctrl = '0;
        w_ctrl[CTRL_CNT_LSB +: CNT_W] = r_count;
        w_ctrl[CTRL_AUTO]             = r_auto;
    end

    always_comb begin
        w_rd_p0 = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (w_widx_p0 == AW'(i)) begin
                w_rd_p0 = (READ_LIVE != 0) ? w_live[i] : w_shadow[i];
            end
        end
        if (w_widx_p0 == AW'(N_REGS)) begin
            w_rd_p0 = w_ctrl;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            r_state    <= ST_IDLE;
            r_rnw_p1   <= 1'b0;
            r_widx_p1  <= '0;
            r_rdata_p1 <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit_p0) begin
                        r_state    <= ST_ACK;
                        r_rnw_p1   <= OPB_RNW;
                        r_widx_p1  <= w_widx_p0;
                        r_rdata_p1 <= OPB_RNW ? w_rd_p0 : 32'd0;
                    end else begin
                        r_rdata_p1 <= '0;
                    end
                end
                ST_ACK: begin
                    r_state    <= ST_IDLE;
                    r_rdata_p1 <= '0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_rdata_p1 <= '0;
                end
            endcase
        end
    end

    // ---- p1: ack cycle, writes and commits take effect at its closing edge ----
    assign w_wr_p1      = (r_state == ST_ACK) && !r_rnw_p1;
    assign w_data_wr_p1 = w_wr_p1 && (r_widx_p1 < AW'(N_REGS));
    assign w_ctrl_wr_p1 = w_wr_p1 && (r_widx_p1 == AW'(N_REGS)) && w_be[0];
    assign w_commit_p1  = w_ctrl_wr_p1 && w_wdata[CTRL_COMMIT];
    assign w_bump_p1    = w_commit_p1 || (w_data_wr_p1 && r_auto);

    // A mode change written together with a commit only affects later transfers.
    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            r_auto   <= 1'b0;
            r_count  <= '0;
            r_update <= 1'b0;
        end else begin
            if (w_ctrl_wr_p1) begin
                r_auto <= w_wdata[CTRL_AUTO];
            end
            if (w_bump_p1) begin
                r_count <= r_count + CNT_W'(1);
            end
            r_update <= w_bump_p1;
        end
    end

    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_slice
        opb_regbank_slice u_slice (
            .clk    (OPB_Clk),
            .rst_n  (OPB_Rst_n),
            .wr_en  (w_data_wr_p1 && (r_widx_p1 == AW'(gi))),
            .be     (w_be),
            .wdata  (w_wdata),
            .commit (w_commit_p1),
            .direct (r_auto),
            .shadow (w_shadow[gi]),
            .live   (w_live[gi])
        );
        assign user_data_out[32*gi +: 32] = w_live[gi];
    end

    // ---- p2: user-visible outputs; bus outputs forced low while reset is held ----
    assign Sl_xferAck  = (r_state == ST_ACK) && OPB_Rst_n;
    assign Sl_DBus     = OPB_Rst_n ? r_rdata_p1 : 32'd0;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_update = r_update;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed plus randomized bench for the OPB register bank, checked against a
// word/byte-level model of the shadow/live bank.
module tb_opb_register_bank_ppc2simulink;

    localparam int          N         = 4;
    localparam int          READ_LIVE = 0;
    localparam logic [31:0] BASE      = 32'h01000A00;
    localparam logic [31:0] HIGH      = 32'h01000AFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [0:31]   abus;
    logic [0:3]    be;
    logic [0:31]   dbus;
    logic          rnw;
    logic          sel;
    logic          seq;
    logic [0:31]   sl_dbus;
    logic          ack;
    logic          err_ack;
    logic          retry;
    logic          tout;
    logic [32*N-1:0] udo;
    logic          upd;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] sh_m [N];
    logic [31:0] lv_m [N];
    logic        auto_m;
    logic [15:0] cnt_m;

    opb_register_bank_ppc2simulink #(
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .N_REGS       (N),
        .READ_LIVE    (READ_LIVE)
    ) dut (
        .OPB_Clk       (clk),
        .OPB_Rst_n     (rst_n),
        .OPB_ABus      (abus),
        .OPB_BE        (be),
        .OPB_DBus      (dbus),
        .OPB_RNW       (rnw),
        .OPB_select    (sel),
        .OPB_seqAddr   (seq),
        .Sl_DBus       (sl_dbus),
        .Sl_xferAck    (ack),
        .Sl_errAck     (err_ack),
        .Sl_retry      (retry),
        .Sl_toutSup    (tout),
        .user_data_out (udo),
        .user_update   (upd)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_addr(input int w);
        return BASE + 32'(4 * w);
    endfunction

    // Byte lane k of the OPB (k=0 is the MSB byte) is replaced when be[k] is set.
    function automatic logic [31:0] merge_m(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [0:3] be_i);
        logic [31:0] r = old_w;
        for (int k = 0; k < 4; k++) begin
            if (be_i[k]) r[31-8*k -: 8] = new_w[31-8*k -: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh_m[i] = '0;
            lv_m[i] = '0;
        end
        auto_m = 1'b0;
        cnt_m  = '0;
    endtask

    task automatic model_commit_all();
        for (int i = 0; i < N; i++) lv_m[i] = sh_m[i];
        cnt_m++;
    endtask

    // Returns what the bus should deliver, then applies the transfer to the model.
    task automatic model_apply(input int w, input logic rd, input logic [31:0] data,
                               input logic [0:3] be_i, output logic [31:0] exp_rd,
                               output logic exp_upd);
        exp_rd  = '0;
        exp_upd = 1'b0;
        if (rd) begin
            if (w < N)       exp_rd = (READ_LIVE != 0) ? lv_m[w] : sh_m[w];
            else if (w == N) exp_rd = {cnt_m, 14'd0, auto_m, 1'b0};
        end else if (w < N) begin
            sh_m[w] = merge_m(sh_m[w], data, be_i);
            if (auto_m) begin
                lv_m[w] = merge_m(lv_m[w], data, be_i);
                cnt_m++;
                exp_upd = 1'b1;
            end
        end else if (w == N && be_i[3]) begin
            if (data[0]) begin
                model_commit_all();
                exp_upd = 1'b1;
            end
            auto_m = data[1];
        end
    endtask

    task automatic check_live(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s:live%0d", tag, i), udo[32*i +: 32], lv_m[i]);
        end
    endtask

    task automatic bus_idle();
        sel  = 1'b0;
        rnw  = 1'b0;
        abus = '0;
        dbus = '0;
        be   = '0;
    endtask

    task automatic do_xfer(input string tag, input int w, input logic rd,
                           input logic [31:0] data, input logic [0:3] be_i);
        logic [31:0] exp_rd;
        logic        exp_upd;
        model_apply(w, rd, data, be_i, exp_rd, exp_upd);
        @(posedge clk); #1;
        sel  = 1'b1;
        abus = reg_addr(w);
        rnw  = rd;
        dbus = data;
        be   = be_i;
        @(posedge clk); #1;
        check($sformatf("%s:ack", tag), 32'(ack), 32'd1);
        check($sformatf("%s:rdata", tag), sl_dbus, exp_rd);
        @(posedge clk); #1;
        bus_idle();
        check($sformatf("%s:ack_low", tag), 32'(ack), 32'd0);
        check($sformatf("%s:dbus_idle", tag), sl_dbus, 32'd0);
        check($sformatf("%s:update", tag), 32'(upd), 32'(exp_upd));
        check_live(tag);
    endtask

    initial begin
        int          ncommit;
        int          nacks;
        logic        prev_ack;
        logic        two_acks;
        int          w;
        logic        rd;
        logic [31:0] data;
        logic [0:3]  be_r;

        seq = 1'b0;
        bus_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst:ack", 32'(ack), 32'd0);
        check("rst:dbus", sl_dbus, 32'd0);
        check("rst:update", 32'(upd), 32'd0);
        check("rst:tied", {29'd0, err_ack, retry, tout}, 32'd0);
        check_live("rst");
        rst_n = 1'b1;
        do_xfer("rst_ctrl_rd", N, 1'b1, 32'd0, 4'b1111);

        do_xfer("wr_r0", 0, 1'b0, 32'h11223344, 4'b1111);
        do_xfer("wr_r1", 1, 1'b0, 32'hAABBCCDD, 4'b1111);
        do_xfer("rd_r0", 0, 1'b1, 32'd0, 4'b1111);
        do_xfer("commit1", N, 1'b0, 32'h00000001, 4'b1111);
        check("commit1:r0", udo[31:0], 32'h11223344);
        check("commit1:r1", udo[63:32], 32'hAABBCCDD);
        @(posedge clk); #1;
        check("commit1:one_pulse", 32'(upd), 32'd0);
        do_xfer("ctrl_rd1", N, 1'b1, 32'd0, 4'b1111);

        do_xfer("wr_r2_ff", 2, 1'b0, 32'hFFFFFFFF, 4'b1111);
        do_xfer("wr_r2_be", 2, 1'b0, 32'h12345678, 4'b0101);
        do_xfer("commit2", N, 1'b0, 32'h00000001, 4'b1111);
        check("be:r2", udo[95:64], 32'hFF34FF78);

        do_xfer("auto_on", N, 1'b0, 32'h00000002, 4'b1111);
        do_xfer("auto_r3", 3, 1'b0, 32'hDEADBEEF, 4'b1111);
        check("auto:r3", udo[127:96], 32'hDEADBEEF);
        do_xfer("auto_ctrl_rd", N, 1'b1, 32'd0, 4'b1111);
        do_xfer("ctrl_no_be3", N, 1'b0, 32'h00000001, 4'b1110);
        do_xfer("oor_rd", N + 1, 1'b1, 32'd0, 4'b1111);
        do_xfer("oor_wr", N + 2, 1'b0, 32'h0BADF00D, 4'b1111);

        // Miss just above the decoded window: never acked, bus stays quiet.
        @(posedge clk); #1;
        sel  = 1'b1;
        rnw  = 1'b1;
        abus = HIGH + 32'd4;
        repeat (3) begin
            @(posedge clk); #1;
            check("miss:ack", 32'(ack), 32'd0);
            check("miss:dbus", sl_dbus, 32'd0);
        end
        bus_idle();

        for (int t = 0; t < 60; t++) begin
            w    = $urandom_range(0, N + 2);
            rd   = 1'($urandom_range(0, 1));
            data = $urandom;
            be_r = 4'($urandom_range(0, 15));
            do_xfer($sformatf("rnd%0d", t), w, rd, data, be_r);
        end

        // Back-to-back commits with select held high until the counter wraps.
        ncommit = 65536 - int'(cnt_m);
        nacks   = 0;
        prev_ack = 1'b0;
        two_acks = 1'b0;
        @(posedge clk); #1;
        sel  = 1'b1;
        rnw  = 1'b0;
        abus = reg_addr(N);
        dbus = 32'h00000001;
        be   = 4'b1111;
        for (int k = 0; k < 2 * ncommit; k++) begin
            @(posedge clk); #1;
            if (ack) nacks++;
            if (ack && prev_ack) two_acks = 1'b1;
            prev_ack = ack;
        end
        bus_idle();
        for (int c = 0; c < ncommit; c++) model_commit_all();
        auto_m = 1'b0;
        check("wrap:acks", 32'(nacks), 32'(ncommit));
        check("wrap:no_double_ack", 32'(two_acks), 32'd0);
        check("wrap:update", 32'(upd), 32'd1);
        check_live("wrap");
        do_xfer("wrap_ctrl_rd", N, 1'b1, 32'd0, 4'b1111);

        // Reset landing in the ack cycle: ack suppressed, bank cleared, pending shadow lost.
        do_xfer("pre_rst_wr", 0, 1'b0, 32'hA5A5A5A5, 4'b1111);
        do_xfer("pre_rst_commit", N, 1'b0, 32'h00000001, 4'b1111);
        @(posedge clk); #1;
        sel  = 1'b1;
        rnw  = 1'b0;
        abus = reg_addr(1);
        dbus = 32'h5555AAAA;
        be   = 4'b1111;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_ack:ack", 32'(ack), 32'd0);
        check("rst_ack:dbus", sl_dbus, 32'd0);
        @(posedge clk); #1;
        bus_idle();
        model_reset();
        check_live("rst_ack");
        check("rst_ack:ack_after", 32'(ack), 32'd0);
        rst_n = 1'b1;
        do_xfer("post_rst_commit", N, 1'b0, 32'h00000001, 4'b1111);
        do_xfer("post_rst_rd_r1", 1, 1'b1, 32'd0, 4'b1111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
